// File: rtl/aes_key_schedule_if.sv
// Key-load handshake, status and round-key read port of the AES-128 key schedule.
// The master side loads keys and reads round keys; the slave side is the schedule.
interface aes_key_schedule_if;
   logic         key_valid;
   logic         key_ready;
   logic [127:0] key_in;
   logic         busy;
   logic         done;
   logic         keys_valid;
   logic [3:0]   rk_idx;
   logic [127:0] rk_out;

   modport master (
      output key_valid, key_in, rk_idx,
      input  key_ready, busy, done, keys_valid, rk_out
   );

   modport slave (
      input  key_valid, key_in, rk_idx,
      output key_ready, busy, done, keys_valid, rk_out
   );
endinterface

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key expansion: one ExpandKey step per clock, all 11 round
// keys kept in a register file behind a combinational read port.
module aes_key_schedule #(
   parameter int          NR      = 10,
   parameter logic [7:0]  RC_INIT = 8'h01
) (
   input  logic          clk,
   input  logic          rst,
   aes_key_schedule_if.slave ks
);

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic {IDLE, EXPAND} state_t;

   state_t       state, state_nxt;
   logic [3:0]   round;
   logic [7:0]   rc;
   logic [31:0]  w [4];
   logic [127:0] rk [NR+1];
   logic [31:0]  temp;
   logic [127:0] next_key;
   logic         accept, last_step, key_ready, busy;
   logic         done, keys_valid;

   // Entry b sits at bits [8*(255-b)+7 -: 8], i.e. top index {~b, 3'b111}.
   function automatic logic [7:0] sub_byte(input logic [7:0] b);
      logic [10:0] top;
      top = {~b, 3'b111};
      return SBOX[top -: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {sub_byte(x[31:24]), sub_byte(x[23:16]), sub_byte(x[15:8]), sub_byte(x[7:0])};
   endfunction

   always_comb begin
      temp        = sub_word({w[3][23:0], w[3][31:24]}) ^ {rc, 24'h0};
      next_key[127:96] = w[0] ^ temp;
      next_key[95:64]  = w[1] ^ next_key[127:96];
      next_key[63:32]  = w[2] ^ next_key[95:64];
      next_key[31:0]   = w[3] ^ next_key[63:32];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: every output of a combinational block gets a default before the
   // case, so no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      key_ready = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      last_step = 1'b0;
      case (state)
         IDLE: begin
            key_ready = 1'b1;
            if (ks.key_valid) begin
               accept    = 1'b1;
               state_nxt = EXPAND;
            end
         end
         EXPAND: begin
            busy = 1'b1;
            if (round == 4'(NR)) begin
               last_step = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: the round-key file is reset along with the control state so that a
   // reset read-back is all zeros; sequential state uses non-blocking only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         round      <= '0;
         rc         <= '0;
         done       <= 1'b0;
         keys_valid <= 1'b0;
         for (int i = 0; i < 4; i++)    w[i]  <= '0;
         for (int i = 0; i <= NR; i++)  rk[i] <= '0;
      end else begin
         done <= last_step;
         if (accept) begin
            rk[0]      <= ks.key_in;
            w[0]       <= ks.key_in[127:96];
            w[1]       <= ks.key_in[95:64];
            w[2]       <= ks.key_in[63:32];
            w[3]       <= ks.key_in[31:0];
            round      <= 4'd1;
            rc         <= RC_INIT;
            keys_valid <= 1'b0;
         end else if (busy) begin
            rk[round] <= next_key;
            w[0]      <= next_key[127:96];
            w[1]      <= next_key[95:64];
            w[2]      <= next_key[63:32];
            w[3]      <= next_key[31:0];
            rc        <= {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00);
            // Hold at NR on the final step so the counter never leaves 0..10.
            if (last_step) keys_valid <= 1'b1;
            else           round      <= round + 4'd1;
         end
      end
   end

   always_comb begin
      ks.key_ready  = key_ready;
      ks.busy       = busy;
      ks.done       = done;
      ks.keys_valid = keys_valid;
      ks.rk_out     = '0;
      if (ks.rk_idx <= 4'(NR)) ks.rk_out = rk[ks.rk_idx];
   end

endmodule
